// File: rtl/motion_switch_debouncer_if.sv
// Switch-conditioning bundle: raw motion switches in, debounced levels and
// per-channel change strobes out.
interface motion_switch_debouncer_if;
  logic       raw_left_fwd;
  logic       raw_left_rev;
  logic       raw_right_fwd;
  logic       raw_right_rev;
  logic       left_fwd;
  logic       left_rev;
  logic       right_fwd;
  logic       right_rev;
  logic [3:0] changed;

  // master drives the raw switches; slave is the debouncer
  modport master (
    output raw_left_fwd, raw_left_rev, raw_right_fwd, raw_right_rev,
    input  left_fwd, left_rev, right_fwd, right_rev, changed
  );
  modport slave (
    input  raw_left_fwd, raw_left_rev, raw_right_fwd, raw_right_rev,
    output left_fwd, left_rev, right_fwd, right_rev, changed
  );
endinterface

// File: rtl/motion_switch_debouncer.sv
// Four-channel motion switch debouncer: 2-FF synchroniser plus counter
// qualification per channel, registered levels and one-cycle change strobes.

module msd_channel #(
  parameter int         CNT_W  = 26,
  parameter logic [25:0] DB_CNT = 26'd4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_changed
);
  typedef enum logic {ST_STABLE, ST_COUNTING} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CNT - 26'd1);

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_changed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= ST_STABLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_changed <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          r_cnt <= '0;
          if (r_sync2 != r_level) begin
            // a single-sample qualification window accepts the new level at once
            if (LAST == '0) begin
              r_level   <= r_sync2;
              r_changed <= 1'b1;
            end else begin
              r_state <= ST_COUNTING;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        ST_COUNTING: begin
          if (r_sync2 == r_level) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt >= LAST) begin
            r_level   <= r_sync2;
            r_changed <= 1'b1;
            r_state   <= ST_STABLE;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_changed = r_changed;
endmodule

module motion_switch_debouncer #(
  parameter bit          simulate   = 1'b0,
  parameter logic [25:0] DB_CNT_HW  = 26'd499_999,
  parameter logic [25:0] DB_CNT_SIM = 26'd4
) (
  input  logic                      clk,
  input  logic                      reset,
  motion_switch_debouncer_if.slave  sw
);
  localparam int          NUM_LANES = 4;
  localparam logic [25:0] DB_CNT    = simulate ? DB_CNT_SIM : DB_CNT_HW;

  // lane order matches the changed bit order: [3]=left_fwd ... [0]=right_rev
  logic [NUM_LANES-1:0] w_raw;
  logic [NUM_LANES-1:0] w_level;
  logic [NUM_LANES-1:0] w_changed;

  assign w_raw = {sw.raw_left_fwd, sw.raw_left_rev, sw.raw_right_fwd, sw.raw_right_rev};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      msd_channel #(
        .CNT_W  (26),
        .DB_CNT (DB_CNT)
      ) u_ch (
        .clk       (clk),
        .reset     (reset),
        .i_raw     (w_raw[g]),
        .o_level   (w_level[g]),
        .o_changed (w_changed[g])
      );
    end
  endgenerate

  assign sw.left_fwd  = w_level[3];
  assign sw.left_rev  = w_level[2];
  assign sw.right_fwd = w_level[1];
  assign sw.right_rev = w_level[0];
  assign sw.changed   = w_changed;
endmodule
